pes_graycode: RTL and testbench



---
 rtl/pes_graycode.sv | 51 +++++
 tb/tb_pes_graycode.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pes_graycode.sv
// pes_graycode: free-running Gray-code counter with count enable.
//
// A binary count of enabled clock edges is kept internally. The Gray form of
// the next count is computed alongside it and captured in its own register on
// the same edge, so gray_count is always the Gray form of bin. Only one output
// bit changes per enabled edge, including the wrap from all-ones back to zero.
//
// Parameters:
//   WIDTH       counter width in bits (>= 2)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears the count and the output
//   enable      count enable, sampled on rising clk
//   gray_count  registered Gray-code count
module pes_graycode #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] gray_count
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  // The output register is loaded from the Gray form of the *next* binary
  // value, so bin and gray_count change on the same edge with no lag.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    if (enable) begin
      bin_d  = bin_q + WIDTH'(1);
      gray_d = bin_d ^ (bin_d >> 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  // Output comes straight from a flop: no combinational path from inputs.
  assign gray_count = gray_q;

endmodule

// File: tb/tb_pes_graycode.sv
// Directed bench for pes_graycode (WIDTH = 8).
module tb_pes_graycode;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] gray_count;

  int errors = 0;
  int checks = 0;

  pes_graycode #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .gray_count(gray_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq_exp [16];
  logic [7:0] prev;
  logic [7:0] n;
  bit         seen [256];

  initial begin
    seq_exp = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C,
                8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08, 8'h18};

    // Reset hold, including an edge with enable high.
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("reset_async_initial", gray_count, 8'h00);
    step();
    check("reset_hold_e0", gray_count, 8'h00);
    enable = 1'b1;
    step();
    check("reset_hold_e1", gray_count, 8'h00);

    // Basic count then hold.
    reset = 1'b0;
    step();
    check("count_1", gray_count, 8'h01);
    step();
    check("count_2", gray_count, 8'h03);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_03", gray_count, 8'h03);
    end

    // Asynchronous reset between edges clears before the next edge.
    #2 reset = 1'b1;
    #1;
    check("reset_async_mid", gray_count, 8'h00);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_after_reset", gray_count, 8'h00);
    end

    // Reset pulse mid-count: no carry-over.
    enable = 1'b1;
    step();
    step();
    step();
    check("pre_pulse_count3", gray_count, 8'h02);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    check("pulse_cleared", gray_count, 8'h00);
    step();
    check("restart_1", gray_count, 8'h01);
    step();
    check("restart_2", gray_count, 8'h03);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("restart_hold", gray_count, 8'h03);
    end

    // 16-step sequence with single-bit steps.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    enable = 1'b1;
    prev   = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step();
      check("seq_value", gray_count, seq_exp[i]);
      check("seq_hamming", $countones(gray_count ^ prev), 1);
      prev = gray_count;
    end

    // Full wrap: 256 enabled edges from reset.
    enable = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    enable = 1'b1;
    prev   = 8'h00;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      check("wrap_value", gray_count, g(8'(i)));
      check("wrap_hamming", $countones(gray_count ^ prev), 1);
      check("wrap_distinct", 32'(seen[gray_count]), 0);
      seen[gray_count] = 1'b1;
      prev = gray_count;
      if (i == 255) check("wrap_edge255", gray_count, 8'h80);
      if (i == 256) check("wrap_edge256", gray_count, 8'h00);
    end

    // Random enable gaps against the enabled-edge count.
    enable = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    n = 8'h00;
    for (int i = 0; i < 300; i++) begin
      enable = 1'($urandom_range(0, 1));
      step();
      if (enable) n = n + 8'd1;
      check("random_gaps", gray_count, g(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
